snoop_cache_ctrl: RTL and testbench



---
 rtl/snoop_cache_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_snoop_cache_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/snoop_cache_ctrl.sv
// rtl/snoop_cache_ctrl.sv - MSI snooping controller for a 2-line direct-mapped cache
// Services processor loads/stores, owns a 9-bit coherence bus word, snoops peer traffic.
module snoop_cache_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [3:0] req_data,
  output logic       req_ready,
  output logic       resp_valid,
  output logic [3:0] resp_data,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       bus_valid,
  output logic [8:0] bus,
  input  logic [3:0] mem_data,
  input  logic       snoop_valid,
  input  logic [8:0] snoop_bus,
  output logic       flush_req
);

  localparam logic [1:0] ReadMiss   = 2'b00;
  localparam logic [1:0] WriteMiss  = 2'b01;
  localparam logic [1:0] Invalidate = 2'b10;
  localparam logic [1:0] WriteBack  = 2'b11;

  localparam logic [1:0] LS_I = 2'b00;
  localparam logic [1:0] LS_S = 2'b01;
  localparam logic [1:0] LS_M = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB_VICTIM = 3'd1;
  localparam logic [2:0] ST_ARB       = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_FILL      = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  localparam logic [1:0] K_REQ    = 2'd0;
  localparam logic [1:0] K_VICTIM = 2'd1;
  localparam logic [1:0] K_FLUSH  = 2'd2;

  logic [2:0] r_line_addr [0:1];
  logic [3:0] r_line_data [0:1];
  logic [1:0] r_line_st   [0:1];

  logic [2:0] r_state;
  logic [1:0] r_kind;
  logic       r_wr;
  logic [2:0] r_addr;
  logic [3:0] r_data;
  logic       r_flush;
  logic [2:0] r_flush_addr;
  logic [3:0] r_flush_data;

  logic       r_req_ready;
  logic       r_resp_valid;
  logic [3:0] r_resp_data;
  logic       r_bus_req;
  logic       r_bus_valid;
  logic [8:0] r_bus;

  logic       w_snp_active;
  logic [1:0] w_st_after [0:1];
  logic       w_flush_set;
  logic [2:0] w_flush_addr;
  logic [3:0] w_flush_data;
  logic       w_req_idx;
  logic       w_req_hit;
  logic       w_cur_idx;
  logic       w_cur_hit;
  logic [1:0] w_cur_msg;
  logic [8:0] w_arb_word;
  logic       w_unused;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign bus_req    = r_bus_req;
  assign bus_valid  = r_bus_valid;
  assign bus        = r_bus;
  assign flush_req  = r_flush;

  // While our own word is on the bus any echo of it on snoop_bus is ignored.
  assign w_snp_active = snoop_valid & ~r_bus_valid;
  assign w_unused     = ^snoop_bus[3:0];

  always_comb begin
    w_flush_set  = 1'b0;
    w_flush_addr = r_flush_addr;
    w_flush_data = r_flush_data;
    for (int i = 0; i < 2; i++) begin
      w_st_after[i] = r_line_st[i];
      if (w_snp_active && r_line_addr[i] == snoop_bus[6:4]) begin
        if (r_line_st[i] == LS_M &&
            (snoop_bus[8:7] == ReadMiss || snoop_bus[8:7] == WriteMiss)) begin
          w_st_after[i] = (snoop_bus[8:7] == ReadMiss) ? LS_S : LS_I;
          w_flush_set   = 1'b1;
          w_flush_addr  = r_line_addr[i];
          w_flush_data  = r_line_data[i];
        end else if (r_line_st[i] == LS_S &&
                     (snoop_bus[8:7] == WriteMiss || snoop_bus[8:7] == Invalidate)) begin
          w_st_after[i] = LS_I;
        end
      end
    end
  end

  // Hit decisions use the post-snoop line state so a same-cycle snoop wins.
  assign w_req_idx = req_addr[0];
  assign w_req_hit = (r_line_addr[w_req_idx] == req_addr) && (w_st_after[w_req_idx] != LS_I);
  assign w_cur_idx = r_addr[0];
  assign w_cur_hit = (r_line_addr[w_cur_idx] == r_addr) && (w_st_after[w_cur_idx] != LS_I);
  assign w_cur_msg = r_wr ? (w_cur_hit ? Invalidate : WriteMiss) : ReadMiss;
  assign w_arb_word = (r_kind == K_FLUSH) ? {WriteBack, r_flush_addr, r_flush_data}
                                          : {w_cur_msg, r_addr, (r_wr ? r_data : 4'h0)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_line_addr[i] <= 3'd0;
        r_line_data[i] <= 4'd0;
        r_line_st[i]   <= LS_I;
      end
      r_state      <= ST_IDLE;
      r_kind       <= K_REQ;
      r_wr         <= 1'b0;
      r_addr       <= 3'd0;
      r_data       <= 4'd0;
      r_flush      <= 1'b0;
      r_flush_addr <= 3'd0;
      r_flush_data <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 4'd0;
      r_bus_req    <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_bus        <= 9'd0;
    end else begin
      r_line_st[0] <= w_st_after[0];
      r_line_st[1] <= w_st_after[1];
      if (w_flush_set) begin
        r_flush      <= 1'b1;
        r_flush_addr <= w_flush_addr;
        r_flush_data <= w_flush_data;
      end
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 4'd0;
      r_bus_valid  <= 1'b0;
      r_bus        <= 9'd0;

      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_wr   <= req_write;
            r_addr <= req_addr;
            r_data <= req_data;
            r_kind <= K_REQ;
            if (w_req_hit && !req_write) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= r_line_data[w_req_idx];
              r_state      <= ST_RESP;
            end else if (w_req_hit && w_st_after[w_req_idx] == LS_M) begin
              r_line_data[w_req_idx] <= req_data;
              r_line_st[w_req_idx]   <= LS_M;
              r_resp_valid           <= 1'b1;
              r_state                <= ST_RESP;
            end else if (!w_req_hit && w_st_after[w_req_idx] == LS_M) begin
              r_bus_req <= 1'b1;
              r_state   <= ST_WB_VICTIM;
            end else begin
              r_bus_req <= 1'b1;
              r_state   <= ST_ARB;
            end
          end else if (r_flush) begin
            r_kind    <= K_FLUSH;
            r_bus_req <= 1'b1;
            r_state   <= ST_ARB;
          end else begin
            r_req_ready <= ~w_flush_set;
          end
        end
        ST_WB_VICTIM: begin
          // A peer snoop may already have demoted the victim; its flush then carries the data.
          if (w_st_after[w_cur_idx] != LS_M) begin
            r_state <= ST_ARB;
          end else if (bus_gnt) begin
            r_bus_req   <= 1'b0;
            r_bus_valid <= 1'b1;
            r_bus       <= {WriteBack, r_line_addr[w_cur_idx], r_line_data[w_cur_idx]};
            r_kind      <= K_VICTIM;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ARB: begin
          if (bus_gnt) begin
            r_bus_req   <= 1'b0;
            r_bus_valid <= 1'b1;
            r_bus       <= w_arb_word;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          case (r_kind)
            K_FLUSH: begin
              r_flush     <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
            K_VICTIM: begin
              r_line_st[w_cur_idx] <= LS_I;
              r_kind               <= K_REQ;
              r_bus_req            <= 1'b1;
              r_state              <= ST_ARB;
            end
            default: begin
              if (r_bus[8:7] == ReadMiss) begin
                r_state <= ST_FILL;
              end else begin
                r_line_addr[w_cur_idx] <= r_addr;
                r_line_data[w_cur_idx] <= r_data;
                r_line_st[w_cur_idx]   <= LS_M;
                r_resp_valid           <= 1'b1;
                r_state                <= ST_RESP;
              end
            end
          endcase
        end
        ST_FILL: begin
          r_line_addr[w_cur_idx] <= r_addr;
          r_line_data[w_cur_idx] <= mem_data;
          r_line_st[w_cur_idx]   <= LS_S;
          r_resp_valid           <= 1'b1;
          r_resp_data            <= mem_data;
          r_state                <= ST_RESP;
        end
        ST_RESP: begin
          r_req_ready <= ~w_flush_set & ~r_flush;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// tb/tb_snoop_cache_ctrl.sv - directed bench for snoop_cache_ctrl
module tb_snoop_cache_ctrl;

  localparam logic [1:0] RM = 2'b00;
  localparam logic [1:0] WM = 2'b01;
  localparam logic [1:0] IV = 2'b10;
  localparam logic [1:0] WB = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [3:0] req_data = 4'd0;
  logic       req_ready;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       bus_req;
  logic       bus_gnt = 1'b1;
  logic       bus_valid;
  logic [8:0] bus;
  logic [3:0] mem_data = 4'd0;
  logic       snoop_valid = 1'b0;
  logic [8:0] snoop_bus = 9'd0;
  logic       flush_req;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] q_bus [$];
  logic [3:0] got_data;
  int         got_lat;

  always #5 clock = ~clock;

  snoop_cache_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_valid  (bus_valid),
    .bus        (bus),
    .mem_data   (mem_data),
    .snoop_valid(snoop_valid),
    .snoop_bus  (snoop_bus),
    .flush_req  (flush_req)
  );

  always @(negedge clock) if (bus_valid) q_bus.push_back(bus);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [2:0] a, input logic [3:0] d);
    int k;
    k = 0;
    @(negedge clock);
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 3'd0;
    req_data  = 4'd0;
  endtask

  task automatic wait_resp(output logic [3:0] data, output int lat);
    lat  = 0;
    data = 4'd0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat  = k;
        data = resp_data;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [2:0] a, input logic [3:0] d,
                       input logic [3:0] exp_data, input int exp_lat);
    q_bus.delete();
    start_req(wr, a, d);
    wait_resp(got_data, got_lat);
    check({tag, "_data"}, got_data, exp_data);
    check({tag, "_lat"}, got_lat, exp_lat);
  endtask

  task automatic snoop(input logic [8:0] w);
    @(negedge clock);
    snoop_valid = 1'b1;
    snoop_bus   = w;
    @(posedge clock);
    #1;
    snoop_valid = 1'b0;
    snoop_bus   = 9'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_outputs", {req_ready, resp_valid, resp_data, bus_req, bus_valid, bus, flush_req}, 0);
    check("reset_line_st", {dut.r_line_st[1], dut.r_line_st[0]}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);

    mem_data = 4'd2;
    do_op("load3_miss", 1'b0, 3'd3, 4'd0, 4'd2, 4);
    check("load3_words", q_bus.size(), 1);
    check("load3_word0", q_bus[0], {RM, 3'd3, 4'd0});
    check("load3_line_s", dut.r_line_st[1], 2'b01);

    do_op("load3_hit", 1'b0, 3'd3, 4'd0, 4'd2, 1);
    check("load3_hit_words", q_bus.size(), 0);

    do_op("store5_miss", 1'b1, 3'd5, 4'd9, 4'd0, 3);
    check("store5_word0", q_bus[0], {WM, 3'd5, 4'd9});
    check("store5_line_m", dut.r_line_st[1], 2'b10);

    mem_data = 4'd4;
    do_op("load3_victim", 1'b0, 3'd3, 4'd0, 4'd4, 6);
    check("victim_words", q_bus.size(), 2);
    check("victim_word0", q_bus[0], {WB, 3'd5, 4'd9});
    check("victim_word1", q_bus[1], {RM, 3'd3, 4'd0});

    mem_data = 4'd1;
    do_op("load2_miss", 1'b0, 3'd2, 4'd0, 4'd1, 4);
    do_op("store2_inv", 1'b1, 3'd2, 4'd7, 4'd0, 3);
    check("store2_word0", q_bus[0], {IV, 3'd2, 4'd7});
    check("store2_line_m", dut.r_line_st[0], 2'b10);
    do_op("load2_hit_m", 1'b0, 3'd2, 4'd0, 4'd7, 1);

    do_op("store4_victim", 1'b1, 3'd4, 4'd6, 4'd0, 5);
    check("store4_word0", q_bus[0], {WB, 3'd2, 4'd7});
    check("store4_word1", q_bus[1], {WM, 3'd4, 4'd6});

    snoop({RM, 3'd4, 4'd0});
    @(negedge clock);
    check("flush_req_set", flush_req, 1);
    check("flush_ready_low", req_ready, 0);
    check("flush_line_s", dut.r_line_st[0], 2'b01);
    for (int k = 0; k < 10; k++) begin
      if (bus_valid) break;
      @(negedge clock);
    end
    check("flush_word", bus, {WB, 3'd4, 4'd6});
    @(negedge clock);
    check("flush_req_clear", flush_req, 0);
    check("flush_ready_back", req_ready, 1);

    mem_data = 4'd3;
    do_op("load2_again", 1'b0, 3'd2, 4'd0, 4'd3, 4);
    bus_gnt = 1'b0;
    q_bus.delete();
    start_req(1'b1, 3'd2, 4'd5);
    @(negedge clock);
    check("arb_bus_req", bus_req, 1);
    check("arb_no_valid", bus_valid, 0);
    snoop({IV, 3'd2, 4'd0});
    bus_gnt = 1'b1;
    wait_resp(got_data, got_lat);
    check("race_resp_seen", got_lat != 0, 1);
    check("race_words", q_bus.size(), 1);
    check("race_word0", q_bus[0], {WM, 3'd2, 4'd5});
    check("race_line_m", dut.r_line_st[0], 2'b10);

    bus_gnt = 1'b0;
    q_bus.delete();
    start_req(1'b0, 3'd7, 4'd0);
    @(negedge clock);
    check("rst_arb_bus_req", bus_req, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_lines", {dut.r_line_st[1], dut.r_line_st[0]}, 0);
    bus_gnt = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mid_no_words", q_bus.size(), 0);
    check("rst_mid_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
